wb_icu80186: RTL
================

Name: wb_icu80186

Overview:
- 80186-compatible interrupt control unit; Wishbone slave in the interrupt-control I/O window 0xFF20–0xFF3E.
- Schedules five sources: timer plus INT0..INT3. INT0 is the synchronised tube p_irq_b.
- Drives the zet wb_tgc_i (intr) request and supplies the interrupt vector during the zet acknowledge (wb_tgc_o).
- Replaces the fixed 0x000C vector mux and the ad-hoc edge latch in the top level.

Parameters:
- VEC_TMR, 8'h08, vector type returned for the timer source.
- VEC_INT0, 8'h0C, vector type for INT0; INT1..INT3 use VEC_INT0+1..+3.
- SYNC_STAGES, 2, synchroniser depth on int_i and tmr_irq_i (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_b  in  1  asynchronous reset, active low.
- wb_adr_i  in  4  word address within the window (adr[4:1]).
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_sel_i  in  2  byte lane enables.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- int_i  in  4  external requests INT3..INT0, active high, asynchronous.
- tmr_irq_i  in  1  timer request, active high.
- intr_o  out  1  interrupt request to the CPU.
- inta_i  in  1  CPU interrupt acknowledge.
- vec_o  out  8  vector type of the last acknowledged source.

Behaviour:
- Reset (async): wb_ack_o=0, wb_dat_o=0, intr_o=0, vec_o=VEC_INT0. IMASK=5'h1F, PRIMSK=7, all PR=7, LTM=0, requests=0, in-service bits=0, synchronisers=0.
- Wishbone access:
  - wb_ack_o is high for exactly one clock, one cycle after stb&cyc. The next ack needs stb to be seen with ack low.
  - Writes take effect on the ack edge and honour wb_sel_i per byte.
  - wb_dat_o is registered and valid with ack. Unmapped offsets read 0 and ignore writes.
- Register map (word offset → register):
  - 0x1 EOI (write-only). Bit15=1: non-specific, clears the highest-priority set ISR bit. Bit15=0: bits[4:0] give the type; the ISR bit of the source with that vector is cleared.
  - 0x4 IMASK[4:0], bit order TMR, I0, I1, I2, I3.
  - 0x5 PRIMSK[2:0].
  - 0x6 INSERV[4:0], read/write.
  - 0x7 REQST[4:0], read-only.
  - 0x9 TCUCON: [3] MSK, [2:0] PR.
  - 0xC..0xF I0CON..I3CON: [4] LTM, [3] MSK, [2:0] PR.
  - MSK bits alias IMASK bits.
- Sources:
  - Each input passes through a SYNC_STAGES flop chain.
  - Edge mode (LTM=0): a rising edge sets REQ, and REQ is cleared when that source is acknowledged. The timer is always edge mode.
  - Level mode (LTM=1): REQ equals the synchronised level.
  - If a new edge and an ack clear hit the same REQ in the same cycle, the edge wins and REQ stays 1.
- Arbitration (combinational, registered into intr_o):
  - A source is eligible when REQ=1, MSK=0, and PR ≤ PRIMSK.
  - The winner has the lowest PR. Ties go in fixed order TMR > I0 > I1 > I2 > I3.
  - intr_o = winner exists AND winner PR < lowest PR among set ISR bits (strictly higher priority; no set ISR bits means no blocking).
  - intr_o updates one clock after any input change.
- Acknowledge:
  - On the inta_i rising edge (inta_i & ~inta_q), the current winner is captured.
  - The winner's ISR bit is set, vec_o is loaded with its type, and its edge REQ is cleared.
  - intr_o drops on the next clock. vec_o holds until the next acknowledge.
  - If there is no winner at the ack edge (spurious), vec_o=VEC_INT0+7 and no state changes.
- Simultaneous events:
  - An EOI write and an ack set in the same cycle: the clear applies first, then the set. The same bit ends up set.
  - A CPU write to INSERV loses to an ack set for the same bit.
- Reset during an outstanding ack or Wishbone cycle aborts it. No ack is generated after the reset is released.

Decomposition:
- Package icu80186_pkg holds:
  - register offset constants;
  - source indices (SRC_TMR=0..SRC_I3=4) and NSRC=5;
  - control-register bit positions (LTM, MSK, PR);
  - the EOI non-specific bit.
- Sub-module icu_src_cell, one instance per source: synchroniser, edge detect, REQ flop with LTM select and ack-clear input.

Test Plan:
- Reset, then read all registers: IMASK=0x1F, PRIMSK=7, I0CON=0x000F, REQST=0; intr_o=0.
- Unmask INT0 (I0CON=0x0002) → pulse int_i[0] → intr_o=1 within SYNC_STAGES+2 clocks. Pulse inta_i → vec_o=0x0C, INSERV=0x02, intr_o=0. Write EOI=0x8000 → INSERV=0.
- Nesting: INT0 PR=2 in service; raise INT1 PR=3 → intr_o stays 0. Raise TMR PR=1 → intr_o=1, ack gives vec_o=0x08, INSERV=0x03.
- Tie plus PRIMSK: INT2 and INT3 both PR=4, pending simultaneously → ack order gives vec 0x0E then 0x0F. With PRIMSK=3, neither raises intr_o.
- Level mode: I1CON=0x0010 with int_i[1] held high → after ack and EOI=0x000D, intr_o reasserts. Drop int_i[1] → REQST bit 2 clears with no ack.
- Async reset asserted mid Wishbone cycle and while intr_o=1 → intr_o=0 and wb_ack_o=0 immediately; registers return to reset values.

Source files
------------

// File: rtl/icu80186_pkg.sv
// rtl/icu80186_pkg.sv - register map, source indices and priority picker for the 80186 ICU
package icu80186_pkg;
    localparam int NSRC    = 5;
    localparam int SRC_TMR = 0;
    localparam int SRC_I0  = 1;
    localparam int SRC_I3  = 4;

    localparam logic [3:0] OFF_EOI    = 4'h1;
    localparam logic [3:0] OFF_IMASK  = 4'h4;
    localparam logic [3:0] OFF_PRIMSK = 4'h5;
    localparam logic [3:0] OFF_INSERV = 4'h6;
    localparam logic [3:0] OFF_REQST  = 4'h7;
    localparam logic [3:0] OFF_TCUCON = 4'h9;
    localparam logic [3:0] OFF_I0CON  = 4'hC;

    localparam int CON_LTM   = 4;
    localparam int CON_MSK   = 3;
    localparam int EOI_NSPEC = 15;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic [2:0] pr;
    } pick_t;

    // Lowest PR wins; strict compare keeps ties on the lower source index.
    function automatic pick_t pick_best(input logic [NSRC-1:0] cand, input logic [3*NSRC-1:0] pr);
        pick_t p;
        p = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && (!p.valid || pr[3*i +: 3] < p.pr)) begin
                p.valid = 1'b1;
                p.idx   = 3'(i);
                p.pr    = pr[3*i +: 3];
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/wb_icu80186_if.sv
// rtl/wb_icu80186_if.sv - Wishbone slave bundle for the ICU register window
interface wb_icu80186_if;
    logic [3:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                    input  wb_dat_o, wb_ack_o);
    modport slave  (input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                    output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/icu_src_cell.sv
// rtl/icu_src_cell.sv - per-source synchroniser, edge detect and request flop
module icu_src_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic i_irq,
    input  logic i_ltm,
    input  logic i_ack_clr,
    output logic o_req
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_req;
    logic                   w_lvl;
    logic                   w_rise;

    assign w_lvl  = r_sync[SYNC_STAGES-1];
    assign w_rise = w_lvl & ~r_prev;
    assign o_req  = i_ltm ? w_lvl : r_req;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= w_lvl;
            // A fresh edge beats a same-cycle acknowledge clear.
            r_req  <= ~i_ltm & (w_rise | (r_req & ~i_ack_clr));
        end
    end
endmodule

// File: rtl/wb_icu80186.sv
// rtl/wb_icu80186.sv - 80186-compatible interrupt control unit with Wishbone register access
module wb_icu80186 #(
    parameter logic [7:0] VEC_TMR     = 8'h08,
    parameter logic [7:0] VEC_INT0    = 8'h0C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_b,
    wb_icu80186_if.slave       wb,
    input  logic [3:0]         int_i,
    input  logic               tmr_irq_i,
    output logic               intr_o,
    input  logic               inta_i,
    output logic [7:0]         vec_o
);
    import icu80186_pkg::*;

    logic              r_ack, r_intr, r_inta_q;
    logic [15:0]       r_dat;
    logic [NSRC-1:0]   r_imask, r_isr, r_ltm;
    logic [2:0]        r_primsk;
    logic [3*NSRC-1:0] r_pr;
    logic [7:0]        r_vec;

    logic              w_acc, w_wr, w_wlo, w_ack_evt, w_intr_d, w_unused;
    logic [15:0]       w_wdat, w_rdat;
    logic [NSRC-1:0]   w_irq_in, w_req, w_elig, w_ack_set, w_eoi_mask, w_isr_nxt;
    pick_t             w_win, w_isr_pick;

    function automatic logic [7:0] f_vec(input logic [2:0] idx);
        return (idx == 3'(SRC_TMR)) ? VEC_TMR : VEC_INT0 + 8'(idx) - 8'(SRC_I0);
    endfunction

    function automatic logic [3:0] f_con_off(input int k);
        return (k == SRC_TMR) ? OFF_TCUCON : OFF_I0CON + 4'(k - SRC_I0);
    endfunction

    assign w_acc    = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
    assign w_wr     = w_acc & wb.wb_we_i;
    assign w_wlo    = w_wr & wb.wb_sel_i[0];
    assign w_wdat   = wb.wb_dat_i & {{8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign w_unused = ^w_wdat[14:5];

    assign w_irq_in[SRC_TMR]       = tmr_irq_i;
    assign w_irq_in[SRC_I3:SRC_I0] = int_i;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        icu_src_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
            .clk       (clk),
            .rst_b     (rst_b),
            .i_irq     (w_irq_in[g]),
            .i_ltm     (r_ltm[g]),
            .i_ack_clr (w_ack_set[g]),
            .o_req     (w_req[g])
        );
        assign w_elig[g] = w_req[g] & ~r_imask[g] & (r_pr[3*g +: 3] <= r_primsk);
    end

    assign w_win      = pick_best(w_elig, r_pr);
    assign w_isr_pick = pick_best(r_isr, r_pr);
    assign w_intr_d   = w_win.valid & (~w_isr_pick.valid | (w_win.pr < w_isr_pick.pr));
    assign w_ack_evt  = inta_i & ~r_inta_q;
    assign w_ack_set  = (w_ack_evt && w_win.valid) ? NSRC'(1) << w_win.idx : '0;

    // In-service update order: CPU write, then EOI clear, then acknowledge set.
    always_comb begin
        w_eoi_mask = '0;
        for (int i = 0; i < NSRC; i++)
            w_eoi_mask[i] = ((f_vec(3'(i)) & 8'h1F) == {3'b0, w_wdat[4:0]});
        w_isr_nxt = r_isr;
        if (w_wlo && wb.wb_adr_i == OFF_INSERV)
            w_isr_nxt = w_wdat[NSRC-1:0];
        if (w_wr && wb.wb_adr_i == OFF_EOI) begin
            if (w_wdat[EOI_NSPEC])
                w_isr_nxt = w_isr_nxt & ~(w_isr_pick.valid ? NSRC'(1) << w_isr_pick.idx : '0);
            else
                w_isr_nxt = w_isr_nxt & ~w_eoi_mask;
        end
        w_isr_nxt = w_isr_nxt | w_ack_set;
    end

    always_comb begin
        w_rdat = 16'h0;
        case (wb.wb_adr_i)
            OFF_IMASK:  w_rdat[NSRC-1:0] = r_imask;
            OFF_PRIMSK: w_rdat[2:0]      = r_primsk;
            OFF_INSERV: w_rdat[NSRC-1:0] = r_isr;
            OFF_REQST:  w_rdat[NSRC-1:0] = w_req;
            default: begin
                for (int k = 0; k < NSRC; k++)
                    if (wb.wb_adr_i == f_con_off(k))
                        w_rdat[4:0] = {r_ltm[k], r_imask[k], r_pr[3*k +: 3]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ack    <= 1'b0;
            r_dat    <= 16'h0;
            r_intr   <= 1'b0;
            r_inta_q <= 1'b0;
            r_imask  <= '1;
            r_primsk <= 3'h7;
            r_pr     <= '1;
            r_ltm    <= '0;
            r_isr    <= '0;
            r_vec    <= VEC_INT0;
        end else begin
            r_ack    <= w_acc;
            r_dat    <= (w_acc && !wb.wb_we_i) ? w_rdat : 16'h0;
            r_inta_q <= inta_i;
            r_intr   <= w_intr_d & ~w_ack_evt;
            r_isr    <= w_isr_nxt;
            if (w_ack_evt)
                r_vec <= w_win.valid ? f_vec(w_win.idx) : VEC_INT0 + 8'd7;
            if (w_wlo) begin
                if (wb.wb_adr_i == OFF_IMASK)  r_imask  <= w_wdat[NSRC-1:0];
                if (wb.wb_adr_i == OFF_PRIMSK) r_primsk <= w_wdat[2:0];
                for (int k = 0; k < NSRC; k++) begin
                    if (wb.wb_adr_i == f_con_off(k)) begin
                        r_imask[k]     <= w_wdat[CON_MSK];
                        r_pr[3*k +: 3] <= w_wdat[2:0];
                        if (k != SRC_TMR) r_ltm[k] <= w_wdat[CON_LTM];
                    end
                end
            end
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign intr_o      = r_intr;
    assign vec_o       = r_vec;
endmodule
